// File: rtl/rf_sched_pkg.sv
// Shared constants for the register-file writeback scheduler.
// Source indices fix the writeback priority order: ALU, then LSU, then MDU.
package rf_sched_pkg;
   localparam int XLEN     = 32;
   localparam int AW       = 5;
   localparam int NREG     = 32;
   localparam int NREQ_DEF = 3;

   localparam int SRC_ALU = 0;
   localparam int SRC_LSU = 1;
   localparam int SRC_MDU = 2;
endpackage

// File: rtl/wb_rr_arbiter.sv
// One-hot grant from a writeback request vector.
// WB_SCHED_RR_EN selects round-robin; otherwise the lowest index wins.
module wb_rr_arbiter
   import rf_sched_pkg::*;
#(
   parameter int NREQ = NREQ_DEF
) (
`ifdef WB_SCHED_RR_EN
   input  logic            clk,
   input  logic            rst,
`endif
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant
);

`ifdef WB_SCHED_RR_EN
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] idx;
   int            idx_int;
   logic          found;

   // Search starts one past the last winner so every source gets a turn.
   always_comb begin
      grant   = '0;
      found   = 1'b0;
      idx_int = 0;
      idx     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx_int = (int'(ptr_q) + k) % NREQ;
         idx     = PW'(idx_int);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   // Any grant is a transfer because ready is the grant itself.
   always_comb begin
      ptr_d = ptr_q;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            ptr_d = PW'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= PW'(NREQ - 1);
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   assign grant = req & (~req + NREQ'(1));
`endif

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler with destination-busy scoreboard.
// Arbitration mode is chosen by WB_SCHED_RR_EN (round-robin) or fixed priority.
module regfile_wb_scheduler
   import rf_sched_pkg::*;
#(
   parameter int NREQ = rf_sched_pkg::NREQ_DEF,
   parameter int XLEN = rf_sched_pkg::XLEN,
   parameter int AW   = rf_sched_pkg::AW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*AW-1:0]   req_rd,
   input  logic [NREQ*XLEN-1:0] req_data,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 issue_valid,
   input  logic [AW-1:0]        issue_rd,
   output logic                 issue_ready,
   output logic                 rf_we,
   output logic [AW-1:0]        rf_rd,
   output logic [XLEN-1:0]      rf_wdata,
   output logic [NREG-1:0]      busy
);

   logic [NREQ-1:0] req_eff;
   logic [NREQ-1:0] grant;
   logic [AW-1:0]   src_rd   [NREQ];
   logic [XLEN-1:0] src_data [NREQ];
   logic [AW-1:0]   sel_rd;
   logic [XLEN-1:0] sel_data;
   logic            wb_any;
   logic            issue_fire;

   logic            rf_we_q, rf_we_d;
   logic [AW-1:0]   rf_rd_q, rf_rd_d;
   logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
   logic [NREG-1:0] busy_q, busy_d;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign src_rd[gi]   = req_rd[gi*AW +: AW];
         assign src_data[gi] = req_data[gi*XLEN +: XLEN];
      end
   endgenerate

   // Masking requests during reset keeps every grant, and thus every transfer, off.
   assign req_eff = rst ? '0 : req_valid;

   wb_rr_arbiter #(.NREQ(NREQ)) u_arb (
`ifdef WB_SCHED_RR_EN
      .clk   (clk),
      .rst   (rst),
`endif
      .req   (req_eff),
      .grant (grant)
   );

   assign req_ready   = grant;
   assign wb_any      = |grant;
   assign issue_ready = ~rst & ((issue_rd == '0) | ~busy_q[issue_rd]);
   assign issue_fire  = issue_valid & issue_ready & (issue_rd != '0);

   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_rd   = src_rd[i];
            sel_data = src_data[i];
         end
      end
   end

   always_comb begin
      rf_we_d    = wb_any & (sel_rd != '0);
      rf_rd_d    = wb_any ? sel_rd : rf_rd_q;
      rf_wdata_d = wb_any ? sel_data : rf_wdata_q;
      busy_d     = busy_q;
      if (wb_any) begin
         busy_d[sel_rd] = 1'b0;
      end
      // Set after clear: a new producer issued this cycle is still outstanding.
      if (issue_fire) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we_q    <= 1'b0;
         rf_rd_q    <= '0;
         rf_wdata_q <= '0;
         busy_q     <= '0;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_rd_q    <= rf_rd_d;
         rf_wdata_q <= rf_wdata_d;
         busy_q     <= busy_d;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_rd    = rf_rd_q;
   assign rf_wdata = rf_wdata_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler; expected register-file writes are queued
// by the stimulus and popped by an independent monitor whenever rf_we is seen high.
module tb_regfile_wb_scheduler;
   localparam int NREQ = 3;
   localparam int XLEN = 32;
   localparam int AW   = 5;

   typedef struct {
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] data;
   } wr_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*AW-1:0]   req_rd;
   logic [NREQ*XLEN-1:0] req_data;
   logic [NREQ-1:0]      req_ready;
   logic                 issue_valid;
   logic [AW-1:0]        issue_rd;
   logic                 issue_ready;
   logic                 rf_we;
   logic [AW-1:0]        rf_rd;
   logic [XLEN-1:0]      rf_wdata;
   logic [31:0]          busy;

   int  total = 0;
   int  bad   = 0;
   wr_t exp_q[$];

   regfile_wb_scheduler #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_rd      (req_rd),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_ready (issue_ready),
      .rf_we       (rf_we),
      .rf_rd       (rf_rd),
      .rf_wdata    (rf_wdata),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", nm, act, exp_v);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
      req_rd[i*AW +: AW]       = rd;
      req_data[i*XLEN +: XLEN] = data;
   endtask

   task automatic push(input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
      wr_t w;
      w.rd   = rd;
      w.data = data;
      exp_q.push_back(w);
   endtask

   // Monitor: every write the register file sees must match the oldest expected one.
   always @(negedge clk) begin
      if (rf_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got rd=%0d data=%0h want=no write", rf_rd, rf_wdata);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            chk("wr_rd", 32'(rf_rd), 32'(w.rd));
            chk("wr_data", rf_wdata, w.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NREQ-1:0] exp_g;
      rst = 1'b1; req_valid = 3'b111; req_rd = '0; req_data = '0;
      issue_valid = 1'b1; issue_rd = 5'd3;
      next_cyc();
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_issue_ready", 32'(issue_ready), 32'h0);
      next_cyc();
      rst = 1'b0; req_valid = '0; issue_valid = 1'b0;

      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("idle_rf_we", 32'(rf_we), 32'h0);
         chk("idle_busy", busy, 32'h0);
         chk("idle_req_ready", 32'(req_ready), 32'h0);
         next_cyc();
      end

      // Reset arrives while source 2 is granted: that write must never happen.
      set_src(2, 5'd3, 32'h33);
      req_valid = 3'b100;
      @(negedge clk);
      chk("midrst_grant", 32'(req_ready), 32'b100);
      rst = 1'b1;
      next_cyc();
      @(negedge clk);
      chk("midrst_rf_we", 32'(rf_we), 32'h0);
      chk("midrst_req_ready", 32'(req_ready), 32'h0);
      next_cyc();
      rst = 1'b0; req_valid = '0;

      // Contention with all three sources held valid.
      set_src(0, 5'd10, 32'hA0);
      set_src(1, 5'd11, 32'hB1);
      set_src(2, 5'd12, 32'hC2);
      req_valid = 3'b111;
      for (int c = 0; c < 6; c++) begin
`ifdef WB_SCHED_RR_EN
         exp_g = 3'b001 << (c % 3);
`else
         exp_g = 3'b001;
`endif
         @(negedge clk);
         chk("contend_grant", 32'(req_ready), 32'(exp_g));
         if (exp_g[0]) push(5'd10, 32'hA0);
         else if (exp_g[1]) push(5'd11, 32'hB1);
         else push(5'd12, 32'hC2);
         next_cyc();
      end
      req_valid = 3'b110;
      @(negedge clk);
      chk("contend_drop0_grant", 32'(req_ready), 32'b010);
      push(5'd11, 32'hB1);
      next_cyc();
      req_valid = '0;
      @(negedge clk);
      chk("contend_busy", busy, 32'h0);
      next_cyc();

      // Single LSU write.
      set_src(1, 5'd5, 32'hDEADBEEF);
      req_valid = 3'b010;
      @(negedge clk);
      chk("single_grant", 32'(req_ready), 32'b010);
      push(5'd5, 32'hDEADBEEF);
      next_cyc();
      req_valid = '0;
      @(negedge clk);
      chk("single_rf_we", 32'(rf_we), 32'h1);
      chk("single_rf_rd", 32'(rf_rd), 32'd5);
      chk("single_rf_wdata", rf_wdata, 32'hDEADBEEF);
      next_cyc();
      @(negedge clk);
      chk("single_after_we", 32'(rf_we), 32'h0);
      chk("single_hold_rd", 32'(rf_rd), 32'd5);
      chk("single_hold_data", rf_wdata, 32'hDEADBEEF);
      next_cyc();

      // Write to x0 is accepted but never reaches the register file.
      set_src(0, 5'd0, 32'h1234);
      req_valid = 3'b001;
      @(negedge clk);
      chk("x0_grant", 32'(req_ready), 32'b001);
      next_cyc();
      req_valid = '0;
      @(negedge clk);
      chk("x0_rf_we", 32'(rf_we), 32'h0);
      next_cyc();

      // Scoreboard set, stall, clear.
      issue_valid = 1'b1; issue_rd = 5'd7;
      @(negedge clk);
      chk("sb_issue_ready", 32'(issue_ready), 32'h1);
      next_cyc();
      issue_valid = 1'b0;
      @(negedge clk);
      chk("sb_busy_set", busy, 32'h80);
      next_cyc();
      issue_valid = 1'b1; issue_rd = 5'd7;
      set_src(2, 5'd7, 32'h77);
      req_valid = 3'b100;
      @(negedge clk);
      chk("sb_stall", 32'(issue_ready), 32'h0);
      chk("sb_wb_grant", 32'(req_ready), 32'b100);
      push(5'd7, 32'h77);
      next_cyc();
      req_valid = '0;
      @(negedge clk);
      chk("sb_busy_clear", busy, 32'h0);
      chk("sb_issue_again", 32'(issue_ready), 32'h1);
      next_cyc();
      issue_valid = 1'b0;
      @(negedge clk);
      chk("sb_busy_reset", busy, 32'h80);
      next_cyc();

      // Same-cycle set and clear of r9: set wins.
      issue_valid = 1'b1; issue_rd = 5'd9;
      set_src(1, 5'd9, 32'h99);
      req_valid = 3'b010;
      @(negedge clk);
      chk("col_issue_ready", 32'(issue_ready), 32'h1);
      chk("col_grant", 32'(req_ready), 32'b010);
      push(5'd9, 32'h99);
      next_cyc();
      issue_valid = 1'b0; req_valid = '0;
      @(negedge clk);
      chk("col_busy", busy, 32'h280);
      chk("col_rf_we", 32'(rf_we), 32'h1);
      chk("col_rf_rd", 32'(rf_rd), 32'd9);
      next_cyc();
      next_cyc();
      next_cyc();
      chk("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Owns the single write port of the 32x32 register file: arbitrates among NREQ writeback sources (ALU, load unit, mul/div) with valid/ready handshakes.
- Drives registered RegWrite/Rd/Write_data into the register file.
- Keeps a destination-busy scoreboard that the decode stage uses to stall RAW/WAW hazards.
- Sits between execution units and the register file.

Parameters:
- NREQ, 3, number of writeback requesters (index 0 = ALU, 1 = LSU, 2 = MDU).
- XLEN, 32, data width.
- AW, 5, register address width (32 registers).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  writeback request per source.
- req_rd  in  NREQ*AW  destination register per source, source i at bits [i*AW +: AW].
- req_data  in  NREQ*XLEN  write data per source, source i at bits [i*XLEN +: XLEN].
- req_ready  out  NREQ  grant/accept per source, combinational.
- issue_valid  in  1  decode is issuing an instruction that writes issue_rd.
- issue_rd  in  AW  destination of the issuing instruction.
- issue_ready  out  1  issue permitted, combinational.
- rf_we  out  1  to register file RegWrite.
- rf_rd  out  AW  to register file Rd.
- rf_wdata  out  XLEN  to register file Write_data.
- busy  out  32  scoreboard, bit r = register r has an outstanding producer.

Behaviour:
- Reset (rst high at a rising edge):
  - rf_we=0, rf_rd=0, rf_wdata=0, busy=0.
  - Round-robin pointer = NREQ-1, so source 0 gets first priority.
  - req_ready=0 and issue_ready=0 while rst is high.
  - Reset mid-transfer discards any pending grant; the next-cycle write is suppressed.
- Arbitration:
  - At most one req_ready bit high per cycle, and only for a source with req_valid=1.
  - req_ready[i] = grant[i]; it never depends on a source being ready elsewhere.
  - A transfer occurs when req_valid[i] & req_ready[i].
  - Sources must hold valid/rd/data stable until accepted.
- Write latency: one cycle. Transfer in cycle N gives rf_we=1 with rf_rd/rf_wdata = the accepted rd/data in cycle N+1.
  - No transfer in N gives rf_we=0 in N+1; rf_rd/rf_wdata hold their previous values.
- x0 handling: a request with rd=0 is accepted normally, but rf_we stays 0 in N+1. busy[0] is constant 0.
- Back-to-back: a new transfer is possible every cycle, giving full write-port throughput.
- Scoreboard:
  - issue_ready = (issue_rd==0) | ~busy[issue_rd], evaluated on registered busy only.
  - Accepted issue with rd≠0 sets busy[issue_rd] at the next edge.
  - Accepted writeback to rd clears busy[rd] at the next edge.
  - Same-cycle set and clear of the same rd: set wins, because the new producer is outstanding.
  - Clear of a non-busy register is harmless (stays 0).
  - Clearing happens at acceptance, so decode can issue a dependent instruction one cycle later.
  - Register-file write-before-read forwarding is the decode stage's responsibility.

Optional Feature:
- Macro: WB_SCHED_RR_EN.
- Defined: round-robin arbitration.
  - Priority search starts at pointer+1 modulo NREQ.
  - The pointer updates to the granted index only on a transfer, and holds when there is no grant.
- Undefined: fixed priority, lowest index wins (ALU > LSU > MDU). The pointer logic is not compiled.

Decomposition:
- Package rf_sched_pkg:
  - XLEN, AW, NREG=32.
  - Source index constants SRC_ALU=0, SRC_LSU=1, SRC_MDU=2.
  - Default NREQ=3.
- Sub-module wb_rr_arbiter:
  - Parameterised NREQ request-vector to one-hot grant, plus the pointer.
  - The fixed-priority path lives in the same sub-module under the macro.
  - Scoreboard and write registers stay in the top module.

Test Plan:
- Reset, then idle: rf_we=0, busy=0, req_ready=000 for 3 cycles. Apply rst mid-grant: the next cycle has rf_we=0.
- Single write: source 1 (LSU) valid, rd=5, data=0xDEADBEEF. Expect req_ready=010 same cycle, then rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF next cycle, then rf_we=0.
- Contention: all three valid, held 6 cycles.
  - RR build: grants 0,1,2,0,1,2.
  - Fixed build: grant stays source 0 until it drops valid.
- x0 write: source 0, rd=0, data=0x1234. Expect req_ready=001 and rf_we=0 next cycle.
- Scoreboard: issue rd=7 sets busy[7] next cycle. Issue rd=7 again gives issue_ready=0. Writeback rd=7 accepted clears busy[7] next cycle, and issue_ready returns to 1.
- Set-wins collision: issue rd=9 while a writeback to rd=9 (not busy) is accepted the same cycle. Expect busy[9]=1 next cycle and rf_we=1 with rf_rd=9.
